// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: machine word size, instruction size,
// default boot PC and the queue entry layout.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INST_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic            filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of in-flight fetches. Entries are allocated on request issue,
// filled in order as responses return, and popped in order by decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_data,
  output logic            head_filled,
  output logic [CW-1:0]   alloc_cnt,
  output logic [CW-1:0]   pend_cnt
);
  fetch_entry_t q [DEPTH];
  logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr;

  assign head_pc     = q[head_ptr].pc;
  assign head_data   = q[head_ptr].data;
  assign head_filled = q[head_ptr].filled;

  // alloc, fill and pop always target distinct entries: alloc takes a free slot,
  // fill an allocated-unfilled one, pop a filled one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) q[i].filled <= 1'b0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
    end else begin
      if (alloc) begin
        q[alloc_ptr].pc     <= alloc_pc;
        q[alloc_ptr].filled <= 1'b0;
        alloc_ptr           <= alloc_ptr + PW'(1);
      end
      if (fill) begin
        q[fill_ptr].data   <= fill_data;
        q[fill_ptr].filled <= 1'b1;
        fill_ptr           <= fill_ptr + PW'(1);
      end
      if (pop) begin
        q[head_ptr].filled <= 1'b0;
        head_ptr           <= head_ptr + PW'(1);
      end
      alloc_cnt <= alloc_cnt + CW'(alloc) - CW'(pop);
      pend_cnt  <= pend_cnt + CW'(alloc) - CW'(fill);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch stage: owns the PC, issues word requests to instruction memory,
// queues returned words and offers {pc, inst} to decode; redirects flush it.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        busy
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   alloc_cnt, pend_cnt, drop_cnt;
  logic [CW:0]     inflight;
  logic            req_fire, resp_drop, resp_fill, pop, head_filled;

  // Slots still owed a response (queued or to-be-dropped) bound new issue.
  assign inflight       = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
  assign imem_req_valid = reset && !halt && !redirect_valid && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && (drop_cnt != '0);
  assign resp_fill = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;

  assign inst_valid = head_filled && !redirect_valid;
  assign pop        = inst_valid && inst_ready;
  assign busy       = (alloc_cnt != '0) || (drop_cnt != '0);

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .reset       (reset),
    .flush       (redirect_valid),
    .alloc       (req_fire),
    .alloc_pc    (fetch_pc),
    .fill        (resp_fill),
    .fill_data   (imem_resp_data),
    .pop         (pop),
    .head_pc     (inst_pc),
    .head_data   (inst_data),
    .head_filled (head_filled),
    .alloc_cnt   (alloc_cnt),
    .pend_cnt    (pend_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~XLEN'(INST_BYTES - 1);
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
    end
  end

  // On redirect every unfilled entry becomes a word to discard; a response
  // landing in the redirect cycle settles one of the outstanding slots.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= drop_cnt + pend_cnt - CW'(imem_resp_valid);
    end else begin
      drop_cnt <= drop_cnt - CW'(resp_drop);
    end
  end

  resp_legal: assert property (@(posedge clk) disable iff (!reset)
    imem_resp_valid |-> (pend_cnt != '0 || drop_cnt != '0));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, configurable-latency memory model.
module tb_fetch_unit;
  logic        clk = 1'b0, reset = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst_data, inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        busy;

  int tests_run = 0, tests_failed = 0;
  int cyc = 0, mem_lat = 1;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  logic [31:0] req_log[$], pop_pc[$], pop_dat[$];

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .busy(busy)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] at_q(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  // Monitor: log accepted requests (feeding the memory) and decode pops.
  always @(negedge clk) begin
    if (reset) begin
      if (imem_req_valid && imem_req_ready) begin
        mreq_t m;
        m.addr = imem_req_addr;
        m.due  = cyc + mem_lat;
        req_log.push_back(imem_req_addr);
        mq.push_back(m);
      end
      if (inst_valid && inst_ready) begin
        pop_pc.push_back(inst_pc);
        pop_dat.push_back(inst_data);
      end
    end
  end

  // Memory: one response per request, in order, shares the fetch reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_resp_valid = 1'b0;
      mq.delete();
    end else begin
      cyc++;
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = inst_of(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    inst_ready = 1'b0; imem_req_ready = 1'b0; mem_lat = 1;
    repeat (2) @(posedge clk);
    #2;
    req_log.delete(); pop_pc.delete(); pop_dat.delete();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_stream;
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (imem_req_addr !== 32'h0 || imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_first_req got v=%b a=%h exp v=1 a=0", imem_req_valid, imem_req_addr); end
    @(negedge clk);
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_no_comb_path got %b exp 0", inst_valid); end
    @(negedge clk);
    tests_run++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin tests_failed++; $display("FAIL stream_first_inst got v=%b pc=%h exp v=1 pc=0", inst_valid, inst_pc); end
    repeat (20) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tests_run++; if (at_q(req_log, i) !== 32'(4*i)) begin tests_failed++; $display("FAIL stream_req[%0d] got %h exp %h", i, at_q(req_log, i), 32'(4*i)); end
      tests_run++; if (at_q(pop_pc, i) !== 32'(4*i)) begin tests_failed++; $display("FAIL stream_pc[%0d] got %h exp %h", i, at_q(pop_pc, i), 32'(4*i)); end
      tests_run++; if (at_q(pop_dat, i) !== inst_of(32'(4*i))) begin tests_failed++; $display("FAIL stream_data[%0d] got %h exp %h", i, at_q(pop_dat, i), inst_of(32'(4*i))); end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    imem_req_ready = 1'b1;
    repeat (6) @(negedge clk);
    tests_run++; if (req_log.size() !== 2) begin tests_failed++; $display("FAIL bp_req_count got %0d exp 2", req_log.size()); end
    tests_run++; if (at_q(req_log, 1) !== 32'h4) begin tests_failed++; $display("FAIL bp_req1 got %h exp 4", at_q(req_log, 1)); end
    tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_full_hold got %b exp 0", imem_req_valid); end
    tests_run++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin tests_failed++; $display("FAIL bp_head got v=%b pc=%h exp v=1 pc=0", inst_valid, inst_pc); end
    tick();
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests_run++; if (req_log.size() - pop_pc.size() > 2) begin tests_failed++; $display("FAIL bp_outstanding got %0d exp <=2", req_log.size() - pop_pc.size()); end
    end
    tests_run++; if (at_q(pop_pc, 0) !== 32'h0 || at_q(pop_pc, 1) !== 32'h4) begin tests_failed++; $display("FAIL bp_pop_order got %h,%h exp 0,4", at_q(pop_pc, 0), at_q(pop_pc, 1)); end
    tests_run++; if (at_q(req_log, 2) !== 32'h8) begin tests_failed++; $display("FAIL bp_req2 got %h exp 8", at_q(req_log, 2)); end
  endtask

  task automatic test_redirect_drop;
    bit seen;
    do_reset();
    imem_req_ready = 1'b1; mem_lat = 3;
    repeat (10) tick();
    inst_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (req_log.size() >= 4) seen = 1'b1;
    end
    tests_run++; if (!seen || at_q(req_log, 3) !== 32'hC) begin tests_failed++; $display("FAIL rd_setup got %h exp c", at_q(req_log, 3)); end
    tick();
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    tests_run++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_cycle got req=%b inst=%b exp 0,0", imem_req_valid, inst_valid); end
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b1;
    repeat (15) tick();
    tests_run++; if (at_q(req_log, 4) !== 32'h100) begin tests_failed++; $display("FAIL rd_new_req got %h exp 100", at_q(req_log, 4)); end
    tests_run++; if (at_q(pop_pc, 2) !== 32'h100) begin tests_failed++; $display("FAIL rd_new_pc got %h exp 100", at_q(pop_pc, 2)); end
    tests_run++; if (at_q(pop_dat, 2) !== inst_of(32'h100)) begin tests_failed++; $display("FAIL rd_new_data got %h exp %h", at_q(pop_dat, 2), inst_of(32'h100)); end
    halt = 1'b1;
    repeat (10) tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rd_drop_drained got busy=%b exp 0", busy); end
  endtask

  task automatic test_redirect_collide;
    bit seen;
    int npop, nreq;
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!inst_valid && imem_resp_valid && imem_req_valid && pop_pc.size() > 0) seen = 1'b1;
    end
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL rc_setup got 0 exp 1"); end
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    npop = pop_pc.size(); nreq = req_log.size();
    @(negedge clk);
    tests_run++; if (imem_resp_valid !== 1'b1 || inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rc_cycle got resp=%b inst=%b exp 1,0", imem_resp_valid, inst_valid); end
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();
    tests_run++; if (at_q(req_log, nreq) !== 32'h200) begin tests_failed++; $display("FAIL rc_new_req got %h exp 200", at_q(req_log, nreq)); end
    tests_run++; if (at_q(pop_pc, npop) !== 32'h200) begin tests_failed++; $display("FAIL rc_first_pc got %h exp 200", at_q(pop_pc, npop)); end
    tests_run++; if (at_q(pop_pc, npop + 1) !== 32'h204) begin tests_failed++; $display("FAIL rc_second_pc got %h exp 204", at_q(pop_pc, npop + 1)); end
  endtask

  task automatic test_halt;
    int nreq;
    do_reset();
    inst_ready = 1'b1; mem_lat = 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin tests_failed++; $display("FAIL halt_stall[%0d] got v=%b a=%h exp v=1 a=0", i, imem_req_valid, imem_req_addr); end
    end
    tick();
    imem_req_ready = 1'b1;
    repeat (6) tick();
    halt = 1'b1;
    nreq = req_log.size();
    @(negedge clk);
    tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL halt_req_valid got %b exp 0", imem_req_valid); end
    repeat (10) tick();
    tests_run++; if (req_log.size() !== nreq) begin tests_failed++; $display("FAIL halt_no_new got %0d exp %0d", req_log.size(), nreq); end
    tests_run++; if (pop_pc.size() !== nreq) begin tests_failed++; $display("FAIL halt_drain got %0d exp %0d", pop_pc.size(), nreq); end
    tests_run++; if (at_q(pop_pc, nreq - 1) !== 32'(4*(nreq-1))) begin tests_failed++; $display("FAIL halt_last_pc got %h exp %h", at_q(pop_pc, nreq - 1), 32'(4*(nreq-1))); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL halt_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_wrap;
    int npop, nreq;
    do_reset();
    imem_req_ready = 1'b1; mem_lat = 3;
    tick(); tick();
    tests_run++; if (req_log.size() !== 2 || busy !== 1'b1) begin tests_failed++; $display("FAIL rw_setup got n=%0d busy=%b exp 2,1", req_log.size(), busy); end
    #2;
    reset = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rw_async got busy=%b req=%b inst=%b exp 0,0,0", busy, imem_req_valid, inst_valid); end
    req_log.delete(); pop_pc.delete(); pop_dat.delete();
    tick();
    reset = 1'b1; mem_lat = 1; inst_ready = 1'b1;
    repeat (4) tick();
    tests_run++; if (at_q(req_log, 0) !== 32'h0) begin tests_failed++; $display("FAIL rw_first_req got %h exp 0", at_q(req_log, 0)); end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    npop = pop_pc.size(); nreq = req_log.size();
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();
    tests_run++; if (at_q(req_log, nreq) !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL rw_req_top got %h exp fffffffc", at_q(req_log, nreq)); end
    tests_run++; if (at_q(req_log, nreq + 1) !== 32'h0) begin tests_failed++; $display("FAIL rw_req_wrap got %h exp 0", at_q(req_log, nreq + 1)); end
    tests_run++; if (at_q(pop_pc, npop) !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL rw_pc_top got %h exp fffffffc", at_q(pop_pc, npop)); end
    tests_run++; if (at_q(pop_pc, npop + 1) !== 32'h0) begin tests_failed++; $display("FAIL rw_pc_wrap got %h exp 0", at_q(pop_pc, npop + 1)); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collide();
    test_halt();
    test_reset_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
